// File: rtl/mem_rr_arbiter_if.sv
// Requester-side bundle of mem_rr_arbiter: per-requester request lanes and the shared response.
// slave is the arbiter's view; master is the requesters' view.
interface mem_rr_arbiter_if #(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        req_wen;
   logic [NREQ-1:0]        req_lock;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [NREQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]      rsp_data;

   modport slave (
      input  req_valid, req_wen, req_lock, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );

   modport master (
      output req_valid, req_wen, req_lock, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-ported memory among NREQ requesters.
// Define MEM_RR_ARBITER_PERF_CNT_EN to add per-requester grant/stall counters.
module mem_rr_arbiter #(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   mem_rr_arbiter_if.slave        req_if,
   output logic [ADDR_W-1:0]      mem_addr_o,
   output logic [DATA_W-1:0]      mem_data_o,
   output logic                   mem_wen_o,
   output logic                   mem_ren_o,
`ifdef MEM_RR_ARBITER_PERF_CNT_EN
   input  logic                   cnt_clr_i,
   output logic [NREQ*16-1:0]     grant_cnt_o,
   output logic [NREQ*16-1:0]     stall_cnt_o,
`endif
   input  logic [DATA_W-1:0]      mem_odata_i
);
   localparam int unsigned IdxW = (NREQ > 2) ? 2 : 1;

   typedef enum logic {StUnlocked, StLocked} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] owner_q, owner_d;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [3:0]      burst_cnt_q, burst_cnt_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

   logic            locked_active;
   logic            win_vld;
   logic [IdxW-1:0] win_idx;
   logic [IdxW-1:0] cand;
   logic [3:0]      cnt_eff;

   always_comb begin
      win_vld       = 1'b0;
      win_idx       = '0;
      cand          = '0;
      locked_active = (state_q == StLocked) && req_if.req_valid[owner_q];
      // Nothing is granted while in reset so the memory sees no strobes.
      if (!rst) begin
         if (locked_active) begin
            win_vld = 1'b1;
            win_idx = owner_q;
         end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
               cand = IdxW'((32'(rr_ptr_q) + k) % NREQ);
               if (!win_vld && req_if.req_valid[cand]) begin
                  win_vld = 1'b1;
                  win_idx = cand;
               end
            end
         end
      end
   end

   always_comb begin
      req_if.req_ready = '0;
      mem_addr_o       = '0;
      mem_data_o       = '0;
      mem_wen_o        = 1'b0;
      mem_ren_o        = 1'b0;
      if (win_vld) begin
         req_if.req_ready = NREQ'(1) << win_idx;
         mem_addr_o       = req_if.req_addr[32'(win_idx)*ADDR_W +: ADDR_W];
         mem_data_o       = req_if.req_wdata[32'(win_idx)*DATA_W +: DATA_W];
         mem_wen_o        = req_if.req_wen[win_idx];
         mem_ren_o        = ~req_if.req_wen[win_idx];
      end
   end

   assign req_if.rsp_data  = mem_odata_i;
   assign req_if.rsp_valid = rsp_valid_q & ~{NREQ{rst}};

   always_comb begin
      // A stale count from a dropped lock must not carry into the next burst.
      cnt_eff     = locked_active ? burst_cnt_q : 4'd0;
      state_d     = locked_active ? StLocked : StUnlocked;
      owner_d     = owner_q;
      burst_cnt_d = cnt_eff;
      rr_ptr_d    = rr_ptr_q;
      rsp_valid_d = '0;
      if (win_vld) begin
         rr_ptr_d = (win_idx == IdxW'(NREQ - 1)) ? '0 : win_idx + IdxW'(1);
         if (req_if.req_lock[win_idx] && ((5'(cnt_eff) + 5'd1) < 5'(MAX_BURST))) begin
            state_d     = StLocked;
            owner_d     = win_idx;
            burst_cnt_d = cnt_eff + 4'd1;
         end else begin
            state_d     = StUnlocked;
            burst_cnt_d = 4'd0;
         end
         if (!req_if.req_wen[win_idx]) rsp_valid_d = NREQ'(1) << win_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StUnlocked;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= 4'd0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

`ifdef MEM_RR_ARBITER_PERF_CNT_EN
   logic [15:0] grant_q [NREQ];
   logic [15:0] stall_q [NREQ];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (rst || cnt_clr_i) begin
            grant_q[i] <= 16'h0000;
            stall_q[i] <= 16'h0000;
         end else begin
            if (req_if.req_valid[i] && req_if.req_ready[i] && grant_q[i] != 16'hFFFF)
               grant_q[i] <= grant_q[i] + 16'd1;
            if (req_if.req_valid[i] && !req_if.req_ready[i] && stall_q[i] != 16'hFFFF)
               stall_q[i] <= stall_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      grant_cnt_o = '0;
      stall_cnt_o = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         grant_cnt_o[i*16 +: 16] = grant_q[i];
         stall_cnt_o[i*16 +: 16] = stall_q[i];
      end
   end
`endif
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed self-checking bench for mem_rr_arbiter with a registered-read memory model.
module tb_mem_rr_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_wen;
   logic       mem_ren;
   logic [7:0] mem_odata = 8'h00;
   logic [7:0] mem [16];
   int         checks = 0;
   int         errors = 0;
`ifdef MEM_RR_ARBITER_PERF_CNT_EN
   logic        cnt_clr = 1'b0;
   logic [31:0] grant_cnt;
   logic [31:0] stall_cnt;
`endif

   mem_rr_arbiter_if #(.NREQ(2), .ADDR_W(4), .DATA_W(8)) bus ();

   mem_rr_arbiter #(.NREQ(2), .ADDR_W(4), .DATA_W(8), .MAX_BURST(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_if      (bus.slave),
      .mem_addr_o  (mem_addr),
      .mem_data_o  (mem_data),
      .mem_wen_o   (mem_wen),
      .mem_ren_o   (mem_ren),
`ifdef MEM_RR_ARBITER_PERF_CNT_EN
      .cnt_clr_i   (cnt_clr),
      .grant_cnt_o (grant_cnt),
      .stall_cnt_o (stall_cnt),
`endif
      .mem_odata_i (mem_odata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wen) mem[mem_addr] <= mem_data;
      if (mem_ren) mem_odata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_rdy [4];
      logic [1:0] exp_rsp [4];
      logic [7:0] exp_dat [4];
      logic [1:0] lock_rdy [7];
      int         k;

      for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
      bus.req_valid = 2'b11;
      bus.req_wen   = 2'b00;
      bus.req_lock  = 2'b00;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // Reset: nothing granted even with requests pending.
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_wen", 32'(mem_wen), 32'h0);
      chk("rst_ren", 32'(mem_ren), 32'h0);
      chk("rst_rsp", 32'(bus.rsp_valid), 32'h0);
      bus.req_valid = 2'b00;
      next();
      rst = 1'b0;

      // Req0 writes 3 <- A5, req1 reads 3.
      bus.req_valid = 2'b01;
      bus.req_wen   = 2'b01;
      bus.req_addr  = {4'h0, 4'h3};
      bus.req_wdata = {8'h00, 8'hA5};
      @(negedge clk);
      chk("wr_ready", 32'(bus.req_ready), 32'h1);
      chk("wr_wen", 32'(mem_wen), 32'h1);
      chk("wr_ren", 32'(mem_ren), 32'h0);
      chk("wr_addr", 32'(mem_addr), 32'h3);
      chk("wr_data", 32'(mem_data), 32'hA5);
      next();
      bus.req_valid = 2'b10;
      bus.req_wen   = 2'b00;
      bus.req_addr  = {4'h3, 4'h0};
      @(negedge clk);
      chk("rd_ready", 32'(bus.req_ready), 32'h2);
      chk("rd_ren", 32'(mem_ren), 32'h1);
      chk("rd_addr", 32'(mem_addr), 32'h3);
      chk("rd_rsp_early", 32'(bus.rsp_valid), 32'h0);
      next();
      bus.req_valid = 2'b00;
      @(negedge clk);
      chk("raw_rsp", 32'(bus.rsp_valid), 32'h2);
      chk("raw_data", 32'(bus.rsp_data), 32'hA5);
      chk("idle_ren", 32'(mem_ren), 32'h0);
      next();
      @(negedge clk);
      chk("raw_rsp_once", 32'(bus.rsp_valid), 32'h0);
      next();

      // Both reading continuously, no lock: strict alternation.
      exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_rsp = '{2'b00, 2'b01, 2'b10, 2'b01};
      exp_dat = '{8'h00, 8'h11, 8'h22, 8'h11};
      bus.req_valid = 2'b11;
      bus.req_addr  = {4'h2, 4'h1};
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("alt_ready%0d", c), 32'(bus.req_ready), 32'(exp_rdy[c]));
         chk($sformatf("alt_rsp%0d", c), 32'(bus.rsp_valid), 32'(exp_rsp[c]));
         if (c > 0) chk($sformatf("alt_data%0d", c), 32'(bus.rsp_data), 32'(exp_dat[c]));
         next();
      end
      bus.req_valid = 2'b00;
      @(negedge clk);
      chk("alt_rsp_last", 32'(bus.rsp_valid), 32'h2);
      chk("alt_data_last", 32'(bus.rsp_data), 32'h22);
      next();

      // Req0 locked burst of 6 writes against a waiting req1.
      lock_rdy = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
      k = 0;
      bus.req_wen  = 2'b01;
      bus.req_lock = 2'b01;
      for (int c = 0; c < 7; c++) begin
         bus.req_valid = {(c <= 4) ? 1'b1 : 1'b0, 1'b1};
         bus.req_addr  = {4'h2, 4'(8 + k)};
         bus.req_wdata = {8'h00, 8'(8'h50 + k)};
         @(negedge clk);
         chk($sformatf("lock_ready%0d", c), 32'(bus.req_ready), 32'(lock_rdy[c]));
         if (c == 5) begin
            chk("lock_rsp1", 32'(bus.rsp_valid), 32'h2);
            chk("lock_rsp1_data", 32'(bus.rsp_data), 32'h22);
         end
         next();
         if (lock_rdy[c] == 2'b01) k++;
      end
      // Read back the 6th write (addr D) from req0.
      bus.req_valid = 2'b01;
      bus.req_wen   = 2'b00;
      bus.req_lock  = 2'b00;
      bus.req_addr  = {4'h0, 4'hD};
      @(negedge clk);
      chk("burst_rd_ready", 32'(bus.req_ready), 32'h1);
      next();
      bus.req_valid = 2'b00;
      @(negedge clk);
      chk("burst_rd_rsp", 32'(bus.rsp_valid), 32'h1);
      chk("burst_rd_data", 32'(bus.rsp_data), 32'h55);
      next();

      // Locked read by req1 then reset: response suppressed, lock dropped, pointer back to 0.
      bus.req_valid = 2'b10;
      bus.req_lock  = 2'b10;
      bus.req_addr  = {4'h2, 4'h1};
      @(negedge clk);
      chk("prerst_ready", 32'(bus.req_ready), 32'h2);
      next();
      rst           = 1'b1;
      bus.req_valid = 2'b00;
      bus.req_lock  = 2'b00;
      @(negedge clk);
      chk("midrst_rsp", 32'(bus.rsp_valid), 32'h0);
      chk("midrst_ready", 32'(bus.req_ready), 32'h0);
      next();
      rst           = 1'b0;
      bus.req_valid = 2'b11;
      @(negedge clk);
      chk("postrst_ready", 32'(bus.req_ready), 32'h1);
      chk("postrst_rsp", 32'(bus.rsp_valid), 32'h0);
      next();
      bus.req_valid = 2'b00;
      @(negedge clk);
      chk("postrst_rsp1", 32'(bus.rsp_valid), 32'h1);
      next();

`ifdef MEM_RR_ARBITER_PERF_CNT_EN
      cnt_clr = 1'b1;
      next();
      cnt_clr = 1'b0;
      bus.req_lock = 2'b10;
      for (int c = 0; c < 11; c++) begin
         bus.req_valid = {1'b1, (c >= 1 && c <= 4) ? 1'b1 : 1'b0};
         @(negedge clk);
         chk($sformatf("perf_ready%0d", c), 32'(bus.req_ready), (c == 4) ? 32'h1 : 32'h2);
         next();
      end
      bus.req_valid = 2'b00;
      bus.req_lock  = 2'b00;
      @(negedge clk);
      chk("grant_cnt1", 32'(grant_cnt[31:16]), 32'd10);
      chk("grant_cnt0", 32'(grant_cnt[15:0]), 32'd1);
      chk("stall_cnt0", 32'(stall_cnt[15:0]), 32'd3);
      chk("stall_cnt1", 32'(stall_cnt[31:16]), 32'd1);
      next();
      cnt_clr = 1'b1;
      next();
      cnt_clr = 1'b0;
      @(negedge clk);
      chk("clr_grant", grant_cnt, 32'h0);
      chk("clr_stall", stall_cnt, 32'h0);
      next();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one single-ported banked memory (1 address/data port, wen/ren strobes, registered read data, 1-cycle read latency) among NREQ requesters.
- Round-robin arbitration with an optional burst lock, so one requester can hold the port for back-to-back accesses.
- Returns read data to the originating requester, tagged by a registered response-valid.
- Sits between requester pipelines and the memory top level; the memory is unchanged.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.
- MAX_BURST, 4, max consecutive grants to one locked requester before forced rotation (legal 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  grant; a transfer occurs when valid&ready in the same cycle
- req_wen  in  NREQ  1 = write, 0 = read
- req_lock  in  NREQ  keep grant after this transfer (burst)
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed write data
- rsp_valid  out  NREQ  read data valid for requester i
- rsp_data  out  DATA_W  read data, shared by all requesters
- mem_addr  out  ADDR_W  to memory
- mem_data  out  DATA_W  to memory
- mem_wen  out  1  to memory
- mem_ren  out  1  to memory
- mem_odata  in  DATA_W  from memory, valid 1 cycle after mem_ren

Behaviour:
- Reset values:
  - rr_ptr=0, owner=none, burst_cnt=0, rsp_valid=0.
  - Combinational outputs mem_wen/mem_ren/req_ready are 0 in the reset cycle.
- Reset mid-operation:
  - An outstanding read's rsp_valid is suppressed.
  - The lock is dropped.
- Grant selection (combinational, one winner per cycle):
  - UNLOCKED state: first requester with req_valid, scanning from rr_ptr upward modulo NREQ.
  - LOCKED state: the owner only, while owner's req_valid=1. If the owner drops valid, the state returns to UNLOCKED in that same cycle and a normal scan runs.
- Ready rules:
  - req_ready[i]=1 only for the winner.
  - req_ready may depend on req_valid.
  - Requesters must hold addr/wdata/wen stable while valid and not ready.
- Memory drive:
  - With a winner: mem_addr/mem_data from the winner; mem_wen=req_wen; mem_ren=~req_wen.
  - With no winner: mem_wen=mem_ren=0, mem_addr=0, mem_data=0.
- On each transfer by winner w:
  - rr_ptr <= (w+1) mod NREQ.
  - If req_lock[w]=1 and burst_cnt+1 < MAX_BURST: state LOCKED, owner=w, burst_cnt increments.
  - Otherwise: state UNLOCKED, burst_cnt=0.
  - The MAX_BURST limit forces rotation even if other requesters are idle. The owner then re-wins only through the normal scan.
- Response path:
  - A read transfer at cycle t sets rsp_valid[w]=1 at cycle t+1, one cycle only.
  - rsp_data = mem_odata (combinational pass-through).
  - Back-to-back reads by different requesters give back-to-back single-cycle rsp_valid pulses in grant order.
- Writes produce no response.
- Read-after-write to the same address in consecutive cycles returns the new data; no forwarding is needed because the write commits at the edge.
- Invariants: at most one bit of req_ready set; at most one bit of rsp_valid set; mem_wen&mem_ren never 1.

Optional Feature:
- Macro: MEM_RR_ARBITER_PERF_CNT_EN.
- When defined:
  - Adds output grant_cnt (NREQ*16): per-requester saturating 16-bit transfer counters.
  - Adds output stall_cnt (NREQ*16): per-requester counters incrementing each cycle with valid&~ready.
  - Adds input cnt_clr (1): synchronous clear.
  - All counters reset to 0 and saturate at 16'hFFFF.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, all valid=0 -> req_ready=0, mem_wen=mem_ren=0, rsp_valid=0.
- Req0 writes addr 4'h3 data 8'hA5, then req1 reads 4'h3 next cycle -> rsp_valid=2'b10 one cycle after the read grant, rsp_data=8'hA5.
- Both requesters valid reads continuously, lock=0 -> grants alternate 0,1,0,1; rsp_valid pulses alternate, each 1 cycle after its grant.
- Req0 lock=1 with 6 back-to-back writes, req1 valid -> req0 granted 4 consecutive cycles (MAX_BURST=4), then req1 granted, then req0 resumes.
- Read granted, rst asserted in the next cycle -> rsp_valid stays 0; after reset the first grant goes to req0 (rr_ptr=0).
- With MEM_RR_ARBITER_PERF_CNT_EN: 10 grants to req1 while req0 stalls 3 cycles -> grant_cnt[1]=10, stall_cnt[0]=3; cnt_clr -> both 0.
